ps2_key_decoder: RTL and testbench

Parametrised PS/2 scan-code decoder placed between `PS2_Controller` and the game FSMs. It replaces the fixed three-key H/S/D decoder. It parses set-2 make, break and extended (E0) sequences and matches them against a configurable key table. For each key it produces a one-cycle press pulse and a held level. It also queues make/break events into a small ready/valid FIFO so that consumers running multi-cycle states do not miss keystrokes.

---
 rtl/ps2_key_decoder_if.sv | 29 ++
 rtl/ps2_key_decoder.sv | 195 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder_if
// Purpose  : Ready/valid key-event bundle from ps2_key_decoder to its consumer.
// Revision : 1.0
// ============================================================================
interface ps2_key_decoder_if #(
    parameter int IDX_W = 2
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_index;
    logic             evt_is_break;

    modport master (
        output evt_valid,
        output evt_index,
        output evt_is_break,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_index,
        input  evt_is_break,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : PS/2 set-2 make/break/E0 parser, key-table match, held/pulse
//            outputs and a ready/valid event FIFO.
//            Optional: define PS2_DEC_TYPEMATIC_EN to re-pulse held keys.
// Revision : 1.0
// ============================================================================
module ps2_key_decoder #(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h076, 9'h023, 9'h01B, 9'h033},
    parameter int                    FIFO_DEPTH     = 4,
    parameter int                    TIMEOUT_CYCLES = 50_000_000
) (
    input  wire logic                CLOCK_50,
    input  wire logic                reset,
    input  wire logic [7:0]          rx_data,
    input  wire logic                rx_valid,
    output logic      [NUM_KEYS-1:0] key_pulse,
    output logic      [NUM_KEYS-1:0] key_held,
    output logic                     evt_overflow,
    output logic      [1:0]          parse_state,
    ps2_key_decoder_if.master        evt
);

    localparam int c_IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_make;
    logic                 w_brk;
    logic                 w_ext;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic                 w_tmo_hit;

    logic                 w_hit;
    logic [c_IDX_W-1:0]   w_hit_idx;
    logic [NUM_KEYS-1:0]  w_hit_oh;
    logic                 w_is_held;
    logic                 w_do_press;
    logic                 w_do_release;

    logic [NUM_KEYS-1:0]  r_pulse;
    logic [NUM_KEYS-1:0]  r_held;

    logic [c_IDX_W:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]     r_wr_ptr;
    logic [c_PTR_W:0]     r_rd_ptr;
    logic                 r_overflow;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_push_ok;

    // ---------------- parser ----------------
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data == 8'hE0)      w_state_nxt = S_EXT;
                    else if (rx_data == 8'hF0) w_state_nxt = S_BRK;
                    else                       w_make      = 1'b1;
                end
                S_EXT: begin
                    w_ext = 1'b1;
                    if (rx_data == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (rx_data != 8'hE0) begin
                        w_make      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_brk       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_tmo_hit) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Abandons a stalled prefix; any received byte restarts the count.
    assign w_tmo_hit = (r_state != S_IDLE) && (r_tmo_cnt == c_TMO_MAX);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (rx_valid || (r_state == S_IDLE) || w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // ---------------- key table match (lowest index wins) ----------------
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_oh  = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[9*i +: 9] == {w_ext, rx_data}) begin
                w_hit       = 1'b1;
                w_hit_idx   = c_IDX_W'(i);
                w_hit_oh    = '0;
                w_hit_oh[i] = 1'b1;
            end
        end
    end

    assign w_is_held = |(r_held & w_hit_oh);
`ifdef PS2_DEC_TYPEMATIC_EN
    assign w_do_press = w_make && w_hit;
`else
    assign w_do_press = w_make && w_hit && !w_is_held;
`endif
    assign w_do_release = w_brk && w_hit && w_is_held;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_pulse <= '0;
            r_held  <= '0;
        end else begin
            r_pulse <= w_do_press ? w_hit_oh : '0;
            r_held  <= (r_held | (w_do_press ? w_hit_oh : '0))
                     & ~(w_do_release ? w_hit_oh : '0);
        end
    end

    // ---------------- event FIFO ----------------
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_push    = w_do_press || w_do_release;
    assign w_pop     = !w_empty && evt.evt_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[c_PTR_W-1:0]] <= {w_do_release, w_hit_idx};
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign evt.evt_valid                       = !w_empty;
    assign {evt.evt_is_break, evt.evt_index}   = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign key_pulse                           = r_pulse;
    assign key_held                            = r_held;
    assign evt_overflow                        = r_overflow;
    assign parse_state                         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Purpose  : Directed self-checking bench for ps2_key_decoder.
// Revision : 1.0
// ============================================================================
module tb_ps2_key_decoder;

`ifdef PS2_DEC_TYPEMATIC_EN
    localparam int c_EXP_PULSES = 3;
    localparam int c_EXP_EVTS   = 4;
`else
    localparam int c_EXP_PULSES = 1;
    localparam int c_EXP_EVTS   = 2;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] key_pulse;
    logic [3:0] key_held;
    logic       evt_overflow;
    logic [1:0] parse_state;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_key_decoder_if #(.IDX_W(2)) evt_if ();

    ps2_key_decoder #(
        .NUM_KEYS      (4),
        .KEY_CODES     ({9'h175, 9'h023, 9'h01B, 9'h033}),
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .key_pulse   (key_pulse),
        .key_held    (key_held),
        .evt_overflow(evt_overflow),
        .parse_state (parse_state),
        .evt         (evt_if)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        evt_if.evt_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Returns the head as observed, then pops it if valid.
    task automatic pop(output logic v, output logic b, output logic [1:0] i);
        v = evt_if.evt_valid;
        b = evt_if.evt_is_break;
        i = evt_if.evt_index;
        if (v) begin
            evt_if.evt_ready = 1'b1;
            tick();
            evt_if.evt_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        evt_if.evt_ready = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({key_pulse, key_held, evt_if.evt_valid, evt_if.evt_index, evt_if.evt_is_break,
             evt_overflow, parse_state} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: got pulse=%b held=%b v=%b idx=%0d brk=%b ovf=%b st=%0d expected all 0",
                     key_pulse, key_held, evt_if.evt_valid, evt_if.evt_index, evt_if.evt_is_break,
                     evt_overflow, parse_state);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_make_break();
        logic v, b;
        logic [1:0] i;
        do_reset();
        send(8'h33);
        n_tests++;
        if ({key_pulse, key_held, evt_if.evt_valid} !== {4'b0001, 4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL mb_press: got pulse=%b held=%b v=%b expected 0001 0001 1",
                     key_pulse, key_held, evt_if.evt_valid);
        end
        tick();
        n_tests++;
        if (key_pulse !== 4'b0000) begin
            n_fail++;
            $display("FAIL mb_pulse_width: got %b expected 0000", key_pulse);
        end
        send(8'hF0);
        n_tests++;
        if (parse_state !== 2'd2) begin
            n_fail++;
            $display("FAIL mb_state_brk: got %0d expected 2", parse_state);
        end
        send(8'h33);
        n_tests++;
        if ({key_pulse, key_held} !== 8'h00) begin
            n_fail++;
            $display("FAIL mb_release: got pulse=%b held=%b expected 0000 0000", key_pulse, key_held);
        end
        pop(v, b, i);
        n_tests++;
        if ({v, b, i} !== 4'b1000) begin
            n_fail++;
            $display("FAIL mb_evt0: got v=%b brk=%b idx=%0d expected 1 0 0", v, b, i);
        end
        pop(v, b, i);
        n_tests++;
        if ({v, b, i} !== 4'b1100) begin
            n_fail++;
            $display("FAIL mb_evt1: got v=%b brk=%b idx=%0d expected 1 1 0", v, b, i);
        end
        n_tests++;
        if (evt_if.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mb_empty: got v=%b expected 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_typematic();
        logic v, b;
        logic [1:0] i;
        logic first_b, last_b;
        logic [1:0] first_i, last_i;
        int pulses = 0;
        int evts   = 0;
        first_b = 1'bx; first_i = 2'bxx; last_b = 1'bx; last_i = 2'bxx;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send((k == 3) ? 8'hF0 : 8'h1B);
            if (key_pulse[1]) pulses++;
        end
        for (int k = 0; k < 8; k++) begin
            pop(v, b, i);
            if (v) begin
                if (evts == 0) begin first_b = b; first_i = i; end
                last_b = b; last_i = i;
                evts++;
            end
        end
        n_tests++;
        if (pulses != c_EXP_PULSES) begin
            n_fail++;
            $display("FAIL tm_pulses: got %0d expected %0d", pulses, c_EXP_PULSES);
        end
        n_tests++;
        if (evts != c_EXP_EVTS) begin
            n_fail++;
            $display("FAIL tm_events: got %0d expected %0d", evts, c_EXP_EVTS);
        end
        n_tests++;
        if ({first_b, first_i, last_b, last_i} !== 6'b001_101) begin
            n_fail++;
            $display("FAIL tm_order: got first=%b/%0d last=%b/%0d expected 0/1 1/1",
                     first_b, first_i, last_b, last_i);
        end
    endtask

    task automatic test_extended();
        logic v, b;
        logic [1:0] i;
        do_reset();
        send(8'hE0);
        n_tests++;
        if (parse_state !== 2'd1) begin
            n_fail++;
            $display("FAIL ext_state: got %0d expected 1", parse_state);
        end
        send(8'h75);
        n_tests++;
        if ({key_pulse, key_held, parse_state} !== {4'b1000, 4'b1000, 2'd0}) begin
            n_fail++;
            $display("FAIL ext_press: got pulse=%b held=%b st=%0d expected 1000 1000 0",
                     key_pulse, key_held, parse_state);
        end
        send(8'h75);
        n_tests++;
        if ({key_pulse, key_held} !== {4'b0000, 4'b1000}) begin
            n_fail++;
            $display("FAIL ext_plain_ignored: got pulse=%b held=%b expected 0000 1000", key_pulse, key_held);
        end
        send(8'hE0);
        send(8'hF0);
        n_tests++;
        if (parse_state !== 2'd3) begin
            n_fail++;
            $display("FAIL ext_brk_state: got %0d expected 3", parse_state);
        end
        send(8'h75);
        n_tests++;
        if (key_held !== 4'b0000) begin
            n_fail++;
            $display("FAIL ext_release: got held=%b expected 0000", key_held);
        end
        pop(v, b, i);
        n_tests++;
        if ({v, b, i} !== 4'b1011) begin
            n_fail++;
            $display("FAIL ext_evt0: got v=%b brk=%b idx=%0d expected 1 0 3", v, b, i);
        end
        pop(v, b, i);
        n_tests++;
        if ({v, b, i} !== 4'b1111) begin
            n_fail++;
            $display("FAIL ext_evt1: got v=%b brk=%b idx=%0d expected 1 1 3", v, b, i);
        end
        n_tests++;
        if (evt_if.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_empty: got v=%b expected 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_overflow();
        logic v, b;
        logic [1:0] i;
        logic [2:0] exp_q [4];
        exp_q[0] = 3'b001; exp_q[1] = 3'b010; exp_q[2] = 3'b100; exp_q[3] = 3'b000;
        do_reset();
        send(8'h33); send(8'h1B); send(8'h23);
        send(8'hF0); send(8'h33);
        send(8'hF0); send(8'h1B);
        send(8'hF0); send(8'h23);
        n_tests++;
        if ({evt_overflow, evt_if.evt_valid, evt_if.evt_is_break, evt_if.evt_index} !== 5'b11000) begin
            n_fail++;
            $display("FAIL of_flag: got ovf=%b v=%b brk=%b idx=%0d expected 1 1 0 0",
                     evt_overflow, evt_if.evt_valid, evt_if.evt_is_break, evt_if.evt_index);
        end
        // Full FIFO: push a new press while popping the head in the same cycle.
        rx_data = 8'h33;
        rx_valid = 1'b1;
        evt_if.evt_ready = 1'b1;
        tick();
        rx_valid = 1'b0;
        evt_if.evt_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pop(v, b, i);
            n_tests++;
            if ({v, b, i} !== {1'b1, exp_q[k]}) begin
                n_fail++;
                $display("FAIL of_entry%0d: got v=%b brk=%b idx=%0d expected 1 %b %0d",
                         k, v, b, i, exp_q[k][2], exp_q[k][1:0]);
            end
        end
        n_tests++;
        if ({evt_if.evt_valid, evt_overflow} !== 2'b01) begin
            n_fail++;
            $display("FAIL of_after: got v=%b ovf=%b expected 0 1", evt_if.evt_valid, evt_overflow);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'hF0);
        repeat (99) tick();
        n_tests++;
        if (parse_state !== 2'd2) begin
            n_fail++;
            $display("FAIL to_before: got %0d expected 2", parse_state);
        end
        tick();
        n_tests++;
        if (parse_state !== 2'd0) begin
            n_fail++;
            $display("FAIL to_expired: got %0d expected 0", parse_state);
        end
        send(8'h23);
        n_tests++;
        if ({key_pulse, key_held, evt_if.evt_is_break, evt_if.evt_index} !== {4'b0100, 4'b0100, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL to_make: got pulse=%b held=%b brk=%b idx=%0d expected 0100 0100 0 2",
                     key_pulse, key_held, evt_if.evt_is_break, evt_if.evt_index);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h33);
        send(8'hE0);
        send(8'hF0);
        #4;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({key_pulse, key_held, evt_if.evt_valid, evt_if.evt_index, evt_if.evt_is_break,
             evt_overflow, parse_state} !== 13'd0) begin
            n_fail++;
            $display("FAIL rm_async: got pulse=%b held=%b v=%b idx=%0d brk=%b ovf=%b st=%0d expected all 0",
                     key_pulse, key_held, evt_if.evt_valid, evt_if.evt_index, evt_if.evt_is_break,
                     evt_overflow, parse_state);
        end
        tick();
        reset = 1'b1;
        tick();
        send(8'h33);
        n_tests++;
        if ({key_pulse, key_held, evt_if.evt_valid, evt_if.evt_is_break, evt_if.evt_index} !==
            {4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL rm_press: got pulse=%b held=%b v=%b brk=%b idx=%0d expected 0001 0001 1 0 0",
                     key_pulse, key_held, evt_if.evt_valid, evt_if.evt_is_break, evt_if.evt_index);
        end
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        test_reset();
        test_make_break();
        test_typematic();
        test_extended();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
